// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - state and mode encodings shared by the binary GCD engine
package gcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_STRIP  = 3'd2,
    ST_REDUCE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_GCD     = 2'd0;
  localparam logic [1:0] MODE_COPRIME = 2'd1;
  localparam logic [1:0] MODE_ITER    = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

endpackage

// File: rtl/gcd_bin_ci.sv
// rtl/gcd_bin_ci.sv - Stein binary GCD engine, one step per enabled cycle
module gcd_bin_ci
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [1:0]       n,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int K_W = $clog2(WIDTH) + 1;
  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a, a_nxt, b, b_nxt, result_nxt, gcd;
  logic [K_W-1:0]    k, k_nxt;
  logic [ITER_W-1:0] iter, iter_nxt, iter_inc;
  logic [1:0]        mode, mode_nxt;
  logic              load;

  function automatic logic [WIDTH-1:0] format_result(input logic [1:0] m,
                                                     input logic [WIDTH-1:0] g,
                                                     input logic [ITER_W-1:0] it);
    case (m)
      MODE_COPRIME: format_result = (g == WIDTH'(1)) ? WIDTH'(1) : '0;
      MODE_ITER:    format_result = WIDTH'(it);
      default:      format_result = g;
    endcase
  endfunction

  assign done     = (state == ST_DONE) && clk_en;
  assign iter_inc = (iter == ITER_MAX) ? iter : iter + ITER_W'(1);

  always_comb begin
    state_nxt  = state;
    a_nxt      = a;
    b_nxt      = b;
    k_nxt      = k;
    iter_nxt   = iter;
    mode_nxt   = mode;
    result_nxt = result;
    gcd        = '0;
    load       = 1'b0;
    // A start strobe wins in every state, so an in-flight operation is dropped silently
    if (start) begin
      a_nxt     = dataa;
      b_nxt     = datab;
      mode_nxt  = n;
      k_nxt     = '0;
      iter_nxt  = '0;
      state_nxt = ST_CHECK;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_CHECK: begin
          if (a == '0) begin
            gcd = b; load = 1'b1; state_nxt = ST_DONE;
          end else if (b == '0) begin
            gcd = a; load = 1'b1; state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_STRIP;
          end
        end
        ST_STRIP: begin
          if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + K_W'(1);
          end else begin
            state_nxt = ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          iter_nxt = iter_inc;
          if (!a[0])        a_nxt = a >> 1;
          else if (!b[0])   b_nxt = b >> 1;
          else if (a == b) begin
            gcd = a << k; load = 1'b1; state_nxt = ST_DONE;
          end
          else if (a > b)   a_nxt = a - b;
          else              b_nxt = b - a;
        end
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
    if (load) result_nxt = format_result(mode, gcd, iter_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      iter   <= '0;
      mode   <= MODE_GCD;
      result <= '0;
    end else if (clk_en) begin
      state  <= state_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      k      <= k_nxt;
      iter   <= iter_nxt;
      mode   <= mode_nxt;
      result <= result_nxt;
    end
  end

endmodule
